// File: rtl/dram_req_pkg.sv
// Shared constants and the read-request word layout for the DRAM traffic generator.
// Optional underrun counter enabled by SRR_UNDERRUN_CNT_EN.
package dram_req_pkg;

    localparam int ADDR_W            = 24;
    localparam int PERIOD_W          = 14;
    localparam int SAMPLES_PER_CHUNK = 8;
    localparam int SUB_W             = $clog2(SAMPLES_PER_CHUNK);

    // 38 meaningful bits, padded to 40 for the traffic generator unpack
    typedef struct packed {
        logic [1:0]          pad;
        logic [PERIOD_W-1:0] period;
        logic [ADDR_W-1:0]   addr;
    } audio_rd_req_t;

endpackage

// File: rtl/sample_read_requester_if.sv
// AXIS read-address request channel (master drives data/valid/tlast).
// No configuration macros.
interface sample_read_requester_if;
    import dram_req_pkg::*;

    audio_rd_req_t data;
    logic          valid;
    logic          ready;
    logic          tlast;

    modport master (output data, output valid, output tlast, input ready);
    modport slave  (input data, input valid, input tlast, output ready);

endinterface

// File: rtl/sample_read_requester_rr_arbiter.sv
// Round-robin arbiter with internal rotating pointer.
// No configuration macros.
module rr_arbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    // first requester at or after the pointer, wrapping modulo N
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[ptr_q + W'(i)]) begin
                any     = 1'b1;
                gnt_idx = ptr_q + W'(i);
            end
        end
        gnt          = '0;
        gnt[gnt_idx] = any;
        ptr_d        = (advance && any) ? gnt_idx + W'(1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sample_read_requester.sv
// Per-voice chunk read requester with round-robin issue to one AXIS output.
// Define SRR_UNDERRUN_CNT_EN to add the saturating underrun_count port.
module sample_read_requester
    import dram_req_pkg::*;
#(
    parameter  int NUM_VOICES = 8,
    localparam int VW         = $clog2(NUM_VOICES)
) (
    input  logic                  clk_dram_ctrl,
    input  logic                  rst_dram_ctrl_n,
    input  logic                  sample_load_complete,
    input  logic                  sample_tick,
    input  logic                  trig_valid,
    input  logic [VW-1:0]         trig_voice,
    input  logic [ADDR_W-1:0]     trig_start_addr,
    input  logic [ADDR_W-1:0]     trig_len,
    sample_read_requester_if.master read_addr_axis,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  underrun
`ifdef SRR_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_count
`endif
);

    localparam int NV = NUM_VOICES;

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [NV-1:0]       active_q, active_d;
    logic [NV-1:0]       pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q [NV];
    logic [ADDR_W-1:0]   addr_d [NV];
    logic [ADDR_W-1:0]   end_q  [NV];
    logic [ADDR_W-1:0]   end_d  [NV];
    logic [SUB_W-1:0]    sub_q  [NV];
    logic [SUB_W-1:0]    sub_d  [NV];
    logic [PERIOD_W-1:0] pper_q [NV];
    logic [PERIOD_W-1:0] pper_d [NV];

    audio_rd_req_t req_q, req_d;
    logic          valid_q, valid_d;
    logic          underrun_q, underrun_d;

    logic [NV-1:0] trig_hit;
    logic [NV-1:0] set_v;
    logic [NV-1:0] ur_evt;
    logic          issue;
    logic [NV-1:0] gnt;
    logic [VW-1:0] gnt_idx;
    logic          any;

    assign issue = !valid_q || read_addr_axis.ready;

    rr_arbiter #(.N(NV)) u_arb (
        .clk     (clk_dram_ctrl),
        .rst_n   (rst_dram_ctrl_n),
        .req     (pend_q),
        .advance (issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        period_d = period_q;
        if (sample_tick) begin
            period_d = period_q + PERIOD_W'(1);
        end
        active_d = active_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        end_d    = end_q;
        sub_d    = sub_q;
        pper_d   = pper_q;
        trig_hit = '0;
        set_v    = '0;
        ur_evt   = '0;
        for (int v = 0; v < NV; v++) begin
            trig_hit[v] = trig_valid && sample_load_complete &&
                          (trig_len != '0) && (trig_voice == VW'(v));
            if (trig_hit[v]) begin
                addr_d[v]   = trig_start_addr;
                end_d[v]    = trig_start_addr + trig_len - ADDR_W'(1);
                sub_d[v]    = '0;
                active_d[v] = 1'b1;
                set_v[v]    = 1'b1;
            end else if (sample_tick && active_q[v]) begin
                if (sub_q[v] != '1) begin
                    sub_d[v] = sub_q[v] + SUB_W'(1);
                end else if (addr_q[v] == end_q[v]) begin
                    active_d[v] = 1'b0;
                end else begin
                    sub_d[v]  = '0;
                    addr_d[v] = addr_q[v] + ADDR_W'(1);
                    set_v[v]  = 1'b1;
                    ur_evt[v] = pend_q[v] && !(issue && gnt[v]);
                end
            end
            if (issue && gnt[v]) begin
                pend_d[v] = 1'b0;
            end
            // a fresh request overwrites any stale one still waiting
            if (set_v[v]) begin
                pend_d[v] = 1'b1;
                pper_d[v] = period_q + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        req_d      = req_q;
        valid_d    = valid_q;
        underrun_d = underrun_q | (|ur_evt);
        if (issue) begin
            valid_d = any;
            if (any) begin
                req_d.pad    = '0;
                req_d.period = pper_q[gnt_idx];
                req_d.addr   = addr_q[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
            period_q   <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            addr_q     <= '{default: '0};
            end_q      <= '{default: '0};
            sub_q      <= '{default: '0};
            pper_q     <= '{default: '0};
            req_q      <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            period_q   <= period_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            sub_q      <= sub_d;
            pper_q     <= pper_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef SRR_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    logic [16:0] ucnt_sum;

    always_comb begin
        ucnt_sum = {1'b0, ucnt_q};
        for (int v = 0; v < NV; v++) begin
            ucnt_sum = ucnt_sum + 17'(ur_evt[v]);
        end
        ucnt_d = ucnt_sum[16] ? 16'hFFFF : ucnt_sum[15:0];
    end

    always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
        if (!rst_dram_ctrl_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign read_addr_axis.data  = req_q;
    assign read_addr_axis.valid = valid_q;
    assign read_addr_axis.tlast = 1'b0;
    assign voice_active         = active_q;
    assign underrun             = underrun_q;

endmodule

// File: tb/tb_sample_read_requester.sv
// Scoreboard bench for sample_read_requester.
// Honours SRR_UNDERRUN_CNT_EN for the underrun_count port.
module tb_sample_read_requester;
    import dram_req_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    logic        tick  = 1'b0;
    logic        tv    = 1'b0;
    logic [2:0]  tvoice = '0;
    logic [23:0] tstart = '0;
    logic [23:0] tlen   = '0;
    logic [7:0]  vact;
    logic        ur;
`ifdef SRR_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_req    = 0;
    int          tb_pc    = 0;
    logic [39:0] sb[$];
    logic [39:0] exp_w;

    sample_read_requester_if axis ();

    always #5 clk = ~clk;

    sample_read_requester #(.NUM_VOICES(8)) dut (
        .clk_dram_ctrl        (clk),
        .rst_dram_ctrl_n      (rst_n),
        .sample_load_complete (load),
        .sample_tick          (tick),
        .trig_valid           (tv),
        .trig_voice           (tvoice),
        .trig_start_addr      (tstart),
        .trig_len             (tlen),
        .read_addr_axis       (axis),
        .voice_active         (vact),
        .underrun             (ur)
`ifdef SRR_UNDERRUN_CNT_EN
        ,
        .underrun_count       (ucnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [23:0] a, input int p);
        return {2'b00, 14'(p), a};
    endfunction

    always @(negedge clk) begin
        if (rst_n && axis.valid && axis.ready) begin
            n_req++;
            if (sb.size() == 0) begin
                check("unexpected_req", 64'(sb.size()), 64'd1);
            end else begin
                exp_w = sb.pop_front();
                check("req_data", 64'(axis.data), 64'(exp_w));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input bit do_trig, input logic [2:0] v,
                        input logic [23:0] s, input logic [23:0] l,
                        input bit do_tick);
        tv     = do_trig;
        tvoice = v;
        tstart = s;
        tlen   = l;
        tick   = do_tick;
        @(posedge clk);
        #1;
        tv   = 1'b0;
        tick = 1'b0;
        if (do_tick) tb_pc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) cyc(1);
        check("drain", 64'(sb.size()), 64'd0);
        cyc(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        tb_pc = 0;
        n_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        axis.ready = 1'b0;
        #1 rst_n = 1'b0;
        cyc(3);
        check("rst_valid", 64'(axis.valid), 64'd0);
        check("rst_data", 64'(axis.data), 64'd0);
        check("rst_tlast", 64'(axis.tlast), 64'd0);
        check("rst_active", 64'(vact), 64'd0);
        check("rst_underrun", 64'(ur), 64'd0);
`ifdef SRR_UNDERRUN_CNT_EN
        check("rst_ucnt", 64'(ucnt), 64'd0);
`endif
        rst_n = 1'b1;
        cyc(1);

        // load gating, then first request latency
        axis.ready = 1'b1;
        load = 1'b0;
        step(1, 3'd0, 24'h000100, 24'd4, 0);
        cyc(4);
        check("gate_active", 64'(vact), 64'd0);
        check("gate_nreq", 64'(n_req), 64'd0);
        load = 1'b1;
        sb.push_back(mk(24'h000100, tb_pc + 1));
        step(1, 3'd0, 24'h000100, 24'd4, 0);
        check("lat_t0_valid", 64'(axis.valid), 64'd0);
        cyc(1);
        check("lat_t1_valid", 64'(axis.valid), 64'd1);
        drain();
        check("load_active", 64'(vact[0]), 64'd1);

        // voice 2, two chunks, 16 ticks
        do_reset();
        axis.ready = 1'b1;
        sb.push_back(mk(24'h000010, tb_pc + 1));
        step(1, 3'd2, 24'h000010, 24'd2, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) sb.push_back(mk(24'h000011, tb_pc + 1));
            if (i == 16) check("v2_active_pre", 64'(vact[2]), 64'd1);
            step(0, 3'd0, 24'h0, 24'h0, 1);
        end
        check("v2_active_post", 64'(vact[2]), 64'd0);
        drain();
        check("v2_nreq", 64'(n_req), 64'd2);

        // round robin from pointer 0: order 0..7
        do_reset();
        axis.ready = 1'b0;
        step(1, 3'd0, 24'h000300, 24'd1, 0);
        for (int v = 7; v >= 1; v--) step(1, 3'(v), 24'h000300 + 24'(v), 24'd1, 0);
        for (int v = 0; v < 8; v++) sb.push_back(mk(24'h000300 + 24'(v), 1));
        axis.ready = 1'b1;
        drain();
        check("rr0_nreq", 64'(n_req), 64'd8);
        // move pointer to 3, then order 3..7,0..2
        sb.push_back(mk(24'h000200, 1));
        step(1, 3'd2, 24'h000200, 24'd1, 0);
        drain();
        axis.ready = 1'b0;
        step(1, 3'd3, 24'h000403, 24'd1, 0);
        for (int k = 0; k < 7; k++) begin
            step(1, 3'(2 - k), 24'h000400 + 24'(3'(2 - k)), 24'd1, 0);
        end
        for (int k = 0; k < 8; k++) sb.push_back(mk(24'h000400 + 24'(3'(3 + k)), 1));
        axis.ready = 1'b1;
        drain();
        check("rr3_nreq", 64'(n_req), 64'd17);

        // underrun under backpressure
        do_reset();
        axis.ready = 1'b1;
        sb.push_back(mk(24'h000500, tb_pc + 1));
        step(1, 3'd0, 24'h000500, 24'd8, 0);
        drain();
        axis.ready = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            if (i == 8) sb.push_back(mk(24'h000501, tb_pc + 1));
            if (i == 24) begin
                check("ur_pre", 64'(ur), 64'd0);
                sb.push_back(mk(24'h000503, tb_pc + 1));
            end
            step(0, 3'd0, 24'h0, 24'h0, 1);
        end
        cyc(3);
        check("hold_valid", 64'(axis.valid), 64'd1);
        check("hold_data", 64'(axis.data), 64'(mk(24'h000501, 8)));
        check("ur_post", 64'(ur), 64'd1);
`ifdef SRR_UNDERRUN_CNT_EN
        check("ucnt", 64'(ucnt), 64'd1);
`endif
        axis.ready = 1'b1;
        drain();
        check("ur_nreq", 64'(n_req), 64'd3);

        // trigger and tick together, then address wrap
        do_reset();
        axis.ready = 1'b1;
        sb.push_back(mk(24'h000600, tb_pc + 1));
        step(1, 3'd1, 24'h000600, 24'd3, 1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) sb.push_back(mk(24'h000601, tb_pc + 1));
            step(0, 3'd0, 24'h0, 24'h0, 1);
        end
        drain();
        check("tt_nreq", 64'(n_req), 64'd2);
        check("tt_ur", 64'(ur), 64'd0);
        sb.push_back(mk(24'hFFFFFF, tb_pc + 1));
        step(1, 3'd1, 24'hFFFFFF, 24'd2, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 8) sb.push_back(mk(24'h000000, tb_pc + 1));
            step(0, 3'd0, 24'h0, 24'h0, 1);
        end
        drain();
        check("wrap_active", 64'(vact[1]), 64'd0);
        check("wrap_nreq", 64'(n_req), 64'd4);

        // asynchronous reset mid-burst
        do_reset();
        axis.ready = 1'b0;
        step(1, 3'd0, 24'h000700, 24'd4, 0);
        step(1, 3'd5, 24'h000705, 24'd4, 0);
        cyc(2);
        check("pre_rst_valid", 64'(axis.valid), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(axis.valid), 64'd0);
        check("arst_active", 64'(vact), 64'd0);
        sb.delete();
        cyc(2);
        rst_n = 1'b1;
        tb_pc = 0;
        n_req = 0;
        axis.ready = 1'b1;
        cyc(1);
        sb.push_back(mk(24'h000800, tb_pc + 1));
        step(1, 3'd4, 24'h000800, 24'd1, 0);
        drain();
        check("restart_nreq", 64'(n_req), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
